fsm_serial_tx: RTL and testbench
================================

Name: fsm_serial_tx

Overview:
State-machine-based serial transmitter. It takes a parallel word over a valid/ready handshake and drives it onto a single-bit line as a framed bit stream: start bit, data LSB-first, optional even parity, stop bit. It is the driving end of a one-wire link whose far end is a clocked sampling FSM. The line idles high.

Parameters:
DATA_W, 8, data word width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles each line bit is held (>=1; value 1 must work)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_valid  input  1  producer has a word on tx_data
tx_data  input  DATA_W  word to transmit, sampled only at acceptance
tx_ready  output  1  block can accept a word; high only in IDLE
tx_out  output  1  serial line, registered, idle/stop level = 1
busy  output  1  frame in progress; equals ~tx_ready
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset); no asynchronous paths.
- Reset values (edge with reset=1): state=IDLE, tx_out=1, done=0, bit/cycle counters=0, shift register=0. tx_ready=1 and busy=0 follow from IDLE.
- tx_ready is combinational from state (state==IDLE). tx_out and done are registers.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1. If tx_valid&&tx_ready at an edge, that edge latches tx_data into the shift register, computes parity = XOR of tx_data, loads the cycle counter, and moves to START. tx_out=0 from that edge.
- START: hold tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx_out = shift[bit index], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit DATA_W-1, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: tx_out = latched parity, held CLKS_PER_BIT cycles. The total count of ones in data plus parity is even. Then go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE. done=1 for exactly the first IDLE cycle.
- Frame length from acceptance edge to return to IDLE = (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles, exactly.
- Back-to-back: tx_ready is high in the done cycle, so a new word may be accepted at that edge. The minimum gap between frames is 1 idle-high cycle, which extends the stop bit.
- tx_valid while busy: ignored, no acceptance. tx_data changes mid-frame have no effect on the frame.
- Reset mid-frame: the next edge forces IDLE and tx_out=1. The frame is abandoned and no done pulse is produced.
- tx_valid asserted in the same cycle as reset: not accepted.
- Counters are sized with $clog2 of the parameters. There are no wrap-around glitches at CLKS_PER_BIT=1 or DATA_W=1.
- No latches; next-state logic is fully specified with a default to IDLE.

Test Plan:
- Reset, DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 -> tx_ready drops at acceptance edge. tx_out bits (4 cycles each) = 0 | 1,0,1,0,0,1,0,1 | 0 | 1. done pulses once, 44 cycles after acceptance.
- Same config, send 0x07 -> parity bit = 1 (three ones). Frame 0|1,1,1,0,0,0,0,0|1|1.
- PARITY_EN=0, CLKS_PER_BIT=1, hold tx_valid=1 with words 0x3C then 0xC3 -> two frames of 10 cycles each. Second frame accepted on the done cycle with exactly 1 idle-high cycle between frames.
- During a frame, toggle tx_valid and change tx_data to 0xFF -> no second acceptance, in-flight bits unchanged, tx_ready=0 until done.
- Assert reset for 1 cycle midway through the DATA bits -> next cycle tx_out=1, tx_ready=1, done never pulses. A fresh 0x5A then transmits correctly.
- Assert tx_valid together with reset -> no frame starts. tx_out stays 1 and busy stays 0 after reset releases, until tx_valid is seen with reset low.

Source files
------------

// File: rtl/fsm_serial_tx.sv
// Framed serial transmitter: accepts a word over valid/ready and shifts it onto an
// idle-high line as start bit, data LSB-first, optional even parity, and stop bit.
module fsm_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    // Handshake: a word transfers on a rising edge where tx_valid && tx_ready and
    // reset is low; tx_ready is high only in IDLE, so tx_valid while busy is ignored.

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [BIT_W-1:0]  r_bit;
    logic [BIT_W-1:0]  w_bit_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic              r_parity;
    logic              w_parity_next;
    logic              r_tx_out;
    logic              w_tx_out_next;
    logic              r_done;
    logic              w_done_next;
    logic              w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    // tx_out is registered, so each branch drives the level of the slot being entered.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_tx_out_next = r_tx_out;
        w_done_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_out_next = 1'b1;
                if (tx_valid) begin
                    w_state_next  = S_START;
                    w_cnt_next    = '0;
                    w_bit_next    = '0;
                    w_shift_next  = tx_data;
                    w_parity_next = ^tx_data;
                    w_tx_out_next = 1'b0;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_state_next  = S_DATA;
                    w_cnt_next    = '0;
                    w_bit_next    = '0;
                    w_tx_out_next = r_shift[0];
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_bit == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            w_state_next  = S_PARITY;
                            w_tx_out_next = r_parity;
                        end else begin
                            w_state_next  = S_STOP;
                            w_tx_out_next = 1'b1;
                        end
                    end else begin
                        // Shifting keeps the current bit at index 0 for any DATA_W.
                        w_bit_next    = r_bit + 1'b1;
                        w_shift_next  = r_shift >> 1;
                        w_tx_out_next = w_shift_next[0];
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next  = S_STOP;
                    w_cnt_next    = '0;
                    w_tx_out_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_STOP: begin
                w_tx_out_next = 1'b1;
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next  = S_IDLE;
                w_cnt_next    = '0;
                w_bit_next    = '0;
                w_tx_out_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx_out <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx_out <= w_tx_out_next;
            r_done   <= w_done_next;
        end
    end

    assign tx_ready  = (r_state == S_IDLE);
    assign busy      = ~tx_ready;
    assign tx_out    = r_tx_out;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Bench for fsm_serial_tx: three parameter sets driven side by side, each checked
// every cycle against a frame-queue model, plus hand-written frame patterns.
module tb_fsm_serial_tx;

    typedef logic pat11_t [11];
    typedef logic pat22_t [22];

    logic       clk;
    logic       reset;
    logic       tx_valid_a [3];
    logic [7:0] tx_data_a  [3];
    logic       tx_ready_a [3];
    logic       tx_out_a   [3];
    logic       busy_a     [3];
    logic       done_a     [3];
    logic [2:0] dbg_state_a [3];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // Line level of frame slot s: start, data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input int dw, input int par, input logic [7:0] d,
                                       input int s);
        int ones;
        if (s == 0) return 1'b0;
        if (s <= dw) return d[s-1];
        if (par != 0 && s == dw + 1) begin
            ones = 0;
            for (int i = 0; i < dw; i++) ones += int'(d[i]);
            return logic'(ones % 2);
        end
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int DW  = (g == 2) ? 1 : 8;
        localparam int CPB = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
        localparam int PAR = (g == 1) ? 0 : 1;

        fsm_serial_tx #(
            .DATA_W(DW),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN(PAR)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .tx_valid(tx_valid_a[g]),
            .tx_data(tx_data_a[g][DW-1:0]),
            .tx_ready(tx_ready_a[g]),
            .tx_out(tx_out_a[g]),
            .busy(busy_a[g]),
            .done(done_a[g]),
            .dbg_state(dbg_state_a[g])
        );

        logic exp_q[$];
        logic exp_busy = 1'b0;
        logic exp_out  = 1'b1;
        logic exp_done = 1'b0;
        bit   armed    = 1'b0;

        // exp_q holds the line level of every remaining cycle of the current frame.
        always @(posedge clk) begin
            if (reset) begin
                exp_q.delete();
                exp_busy = 1'b0;
                exp_out  = 1'b1;
                exp_done = 1'b0;
                armed    = 1'b1;
            end else if (exp_busy) begin
                if (exp_q.size() > 0) begin
                    exp_out  = exp_q.pop_front();
                    exp_done = 1'b0;
                end else begin
                    exp_busy = 1'b0;
                    exp_out  = 1'b1;
                    exp_done = 1'b1;
                end
            end else begin
                exp_done = 1'b0;
                exp_out  = 1'b1;
                if (tx_valid_a[g]) begin
                    for (int s = 0; s < 2 + DW + PAR; s++)
                        for (int c = 0; c < CPB; c++)
                            exp_q.push_back(frame_bit(DW, PAR, tx_data_a[g], s));
                    exp_out  = exp_q.pop_front();
                    exp_busy = 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                check_bit($sformatf("cfg%0d tx_out", g), tx_out_a[g], exp_out);
                check_bit($sformatf("cfg%0d tx_ready", g), tx_ready_a[g], ~exp_busy);
                check_bit($sformatf("cfg%0d busy", g), busy_a[g], exp_busy);
                check_bit($sformatf("cfg%0d done", g), done_a[g], exp_done);
            end
        end
    end

    // Sends one word on cfg0 (8 bits, 4 clocks/bit, parity) and checks a literal frame.
    task automatic frame0(input string name, input logic [7:0] d, input pat11_t pat,
                          input bit junk);
        tx_data_a[0]  = d;
        tx_valid_a[0] = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (junk && i < 43) begin
                tx_valid_a[0] = 1'($urandom_range(0, 1));
                tx_data_a[0]  = 8'hFF;
            end else begin
                tx_valid_a[0] = 1'b0;
            end
            if (i < 44) begin
                check_bit({name, " bit"}, tx_out_a[0], pat[i/4]);
                check_bit({name, " ready low"}, tx_ready_a[0], 1'b0);
            end else begin
                check_bit({name, " ready in done cycle"}, tx_ready_a[0], 1'b1);
            end
            check_bit({name, " done"}, done_a[0], logic'(i == 44));
        end
    endtask

    initial begin
        pat11_t pat_a5;
        pat11_t pat_07;
        pat11_t pat_5a;
        pat22_t pat_b2b;
        pat_a5  = '{0, 1,0,1,0,0,1,0,1, 0, 1};
        pat_07  = '{0, 1,1,1,0,0,0,0,0, 1, 1};
        pat_5a  = '{0, 0,1,0,1,1,0,1,0, 0, 1};
        pat_b2b = '{0, 0,0,1,1,1,1,0,0, 1, 1, 0, 1,1,0,0,0,0,1,1, 1, 1};

        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            tx_valid_a[g] = 1'b0;
            tx_data_a[g]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset tx_out", tx_out_a[0], 1'b1);
        check_bit("reset tx_ready", tx_ready_a[0], 1'b1);
        check_bit("reset busy", busy_a[0], 1'b0);
        check_bit("reset done", done_a[0], 1'b0);
        reset = 1'b0;

        frame0("a5", 8'hA5, pat_a5, 1'b0);
        frame0("07 with junk", 8'h07, pat_07, 1'b1);
        @(negedge clk);
        check_bit("no accept while busy", busy_a[0], 1'b0);

        // cfg1: no parity, 1 clock/bit, tx_valid held across two words.
        tx_data_a[1]  = 8'h3C;
        tx_valid_a[1] = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 0) tx_data_a[1] = 8'hC3;
            if (i == 11) tx_valid_a[1] = 1'b0;
            check_bit("b2b tx_out", tx_out_a[1], pat_b2b[i]);
            check_bit("b2b done", done_a[1], logic'(i == 10 || i == 21));
            if (i == 10) check_bit("b2b ready in done cycle", tx_ready_a[1], 1'b1);
        end

        // Abort a cfg0 frame in the middle of its data bits.
        tx_data_a[0]  = 8'($urandom);
        tx_valid_a[0] = 1'b1;
        @(negedge clk);
        tx_valid_a[0] = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_bit("abort tx_out", tx_out_a[0], 1'b1);
        check_bit("abort tx_ready", tx_ready_a[0], 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check_bit("abort no done", done_a[0], 1'b0);
        end
        frame0("5a after abort", 8'h5A, pat_5a, 1'b0);

        // tx_valid coinciding with reset must not start a frame.
        @(negedge clk);
        reset         = 1'b1;
        tx_valid_a[0] = 1'b1;
        tx_data_a[0]  = 8'h81;
        @(negedge clk);
        reset         = 1'b0;
        tx_valid_a[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("valid with reset tx_out", tx_out_a[0], 1'b1);
            check_bit("valid with reset busy", busy_a[0], 1'b0);
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            for (int g = 0; g < 3; g++) begin
                tx_valid_a[g] = ($urandom_range(0, 3) == 0);
                tx_data_a[g]  = 8'($urandom);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int g = 0; g < 3; g++) tx_valid_a[g] = 1'b0;
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
